spi_xfer_scheduler: RTL
=======================

# spi_xfer_scheduler

Multi-requester transfer scheduler in front of the SPI master control/select core. Arbitrates up to NREQ requesters round-robin, launches one frame at a time by pulsing `send_data` with the winner's byte, and tracks the frame through `tip`/`receive_data`. Returns received data and per-requester completion or error status, and guards each phase with a watchdog. Holds off all launches unless the core is in an active master mode.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DW`, default 8: transfer data width.
- `GAP`, default 2: idle cycles enforced between frames (ss stays high), 1..15.
- `PCLK  in  1`: single clock. All logic is rising-edge.
- `PRESETn  in  1`: asynchronous, active-low reset.
- `mstr  in  1`, `spiswai  in  1`, `spi_mode  in  2`: core mode. `active = mstr & !spiswai & (spi_mode==2'b00 | spi_mode==2'b01)`.
- `BaudRateDivisor  in  12`: current divisor; frame length is `BaudRateDivisor<<4` PCLKs.
- `req  in  NREQ`: level request. Hold until `gnt`. Dropping it earlier withdraws the request.
- `req_wdata  in  NREQ*DW`: requester i's byte in slice [i*DW +: DW].
- `gnt  out  NREQ`: one-hot, single-cycle acceptance pulse.
- `done  out  NREQ`: one-hot, single-cycle success pulse.
- `err  out  NREQ`: one-hot, single-cycle failure pulse (timeout or abort).
- `rdata  out  DW`: last received byte. Valid from the `done` cycle and held until the next `done`.
- `send_data  out  1`, `tx_data  out  DW`: frame launch to the core.
- `tip  in  1`, `receive_data  in  1`, `rx_data  in  DW`: core status and data.
- `busy  out  1`: high in every state except IDLE.
- `owner  out  clog2(NREQ)`: index of the current or last granted requester.

## Operation
- States: IDLE, LAUNCH, WAIT_TIP, XFER, GAP.
- **IDLE**
  - If `active & |req & BaudRateDivisor!=0`, pick the winner round-robin, starting at `last+1` and wrapping modulo NREQ.
  - Register `owner`, latch `tx_data` from the winner's slice, advance `last` to the winner, and go to LAUNCH.
  - If `BaudRateDivisor==0`, no grant is issued; requests stay pending.
- **LAUNCH** (exactly 1 cycle)
  - `send_data=1` and `gnt[owner]=1`.
  - Load the watchdog with 4 and go to WAIT_TIP.
- **WAIT_TIP**
  - `tip=1`: load the watchdog with `(BaudRateDivisor<<4)+8` (17-bit, no overflow) and go to XFER.
  - Watchdog reaches 0: pulse `err[owner]`, go to GAP.
- **XFER**
  - `receive_data=1`: capture `rx_data` into `rdata`, pulse `done[owner]`, go to GAP.
  - `active` falls: abort. Pulse `err[owner]`, go to GAP.
  - Watchdog reaches 0: pulse `err[owner]`, go to GAP.
  - Priority when events coincide: `receive_data` > abort > timeout.
- **GAP**
  - Count GAP cycles with `send_data=0`, then go to IDLE.
  - `req` is ignored during GAP.
- Only one of `gnt`/`done`/`err` is high in any cycle. At most one bit of each is set.
- `tx_data` is stable from LAUNCH until the next LAUNCH.

## Timing
- Reset values:
  - State IDLE, `last=NREQ-1` (so requester 0 wins first).
  - `gnt=done=err=0`, `send_data=0`, `tx_data=0`, `rdata=0`, `busy=0`, `owner=0`, watchdog 0.
- Grant latency: `req` sampled in IDLE at edge N, so `gnt` and `send_data` are high during cycle N+1.
- `done` is high the cycle after `receive_data` is sampled.
- Back-to-back throughput: one frame per (`BaudRateDivisor<<4`) + GAP + ~4 cycles.
- Reset mid-frame returns immediately to reset values. No `done`/`err` is emitted for the killed frame.
- A `req` withdrawn in the same cycle IDLE samples it is not granted. Sampling is registered.

## Structure
- `spi_pkg` (shared):
  - state enum `sched_state_e`
  - `WDOG_TIP=4`, `WDOG_MARGIN=8`
  - `active` mode decode function, reused by other SPI blocks
- Sub-module `spi_rr_arbiter`:
  - Inputs: `req`, `last`. Output: one-hot winner and its index.
  - Combinational, parameterised by NREQ.
- The watchdog and the GAP counter share one 17-bit down-counter in the top level.

## Test plan
- Single request: `req=4'b0010`, `req_wdata[15:8]=8'hA5`, BRD=1 → `gnt=4'b0010` one cycle with `send_data=1`, `tx_data=8'hA5`; core returns `rx_data=8'h3C` → `done=4'b0010`, `rdata=8'h3C`.
- Round-robin fairness: `req=4'b1111` held through 8 frames → grant order 0,1,2,3,0,1,2,3; exactly GAP idle cycles between `send_data` pulses.
- Timeouts:
  - `tip` never asserts → `err[owner]` exactly 5 cycles after LAUNCH.
  - With BRD=2, `tip` high but no `receive_data` → `err` after 40 cycles in XFER.
- Mode gating:
  - `spiswai=1` or `mstr=0` with `req` pending → no `gnt`.
  - `spiswai` raised mid-XFER → `err[owner]` next cycle, then GAP, then IDLE.
  - `BaudRateDivisor=0` → no grant until it is nonzero.
- Async reset mid-XFER: PRESETn low → all outputs at reset values within the same cycle; after release, `req=4'b1000` is granted to requester 3 with no stale `done`.
- Collision: `receive_data` and `active` fall in the same cycle → `done` (not `err`); `rdata` updated.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master support blocks: scheduler states,
// watchdog constants and the master-mode decode.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_TIP,
    ST_XFER,
    ST_GAP
  } sched_state_e;

  localparam logic [16:0] WDOG_TIP    = 17'd4;
  localparam logic [16:0] WDOG_MARGIN = 17'd8;

  // Core is usable for new frames only in a running master mode 00 or 01.
  function automatic logic spi_active(input logic       mstr,
                                      input logic       spiswai,
                                      input logic [1:0] spi_mode);
    return mstr & ~spiswai & ((spi_mode == 2'b00) | (spi_mode == 2'b01));
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1, wrapping,
// and reports the first pending requester as one-hot and as an index.
module spi_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            valid
);

  int cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        win_idx   = IW'(cand);
        win[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Round-robin frame scheduler in front of the SPI master core: launches one
// frame at a time, tracks tip/receive_data, and reports done/err per requester.
module spi_xfer_scheduler
  import spi_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int GAP  = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    mstr,
  input  logic                    spiswai,
  input  logic [1:0]              spi_mode,
  input  logic [11:0]             BaudRateDivisor,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         err,
  output logic [DW-1:0]           rdata,
  output logic                    send_data,
  output logic [DW-1:0]           tx_data,
  input  logic                    tip,
  input  logic                    receive_data,
  input  logic [DW-1:0]           rx_data,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int          IW       = $clog2(NREQ);
  localparam logic [16:0] GAP_LOAD = 17'(GAP);

  sched_state_e    state_reg, state_next;
  logic [IW-1:0]   last_reg, last_next;
  logic [IW-1:0]   owner_reg, owner_next;
  logic [DW-1:0]   tx_reg, tx_next;
  logic [DW-1:0]   rdata_reg, rdata_next;
  logic [16:0]     wdog_reg, wdog_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic [NREQ-1:0] err_reg, err_next;

  logic            active;
  logic            wdog_expire;
  logic [16:0]     frame_load;
  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic [DW-1:0]   win_data;
  logic [NREQ-1:0] owner_mask;

  assign active      = spi_active(mstr, spiswai, spi_mode);
  assign frame_load  = {1'b0, BaudRateDivisor, 4'b0000} + WDOG_MARGIN;
  // The shared counter "reaches 0" on the cycle it would step from 1 to 0.
  assign wdog_expire = (wdog_reg <= 17'd1);

  spi_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req     (req),
    .last    (last_reg),
    .win     (win),
    .win_idx (win_idx),
    .valid   (win_valid)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_data = win_data | (req_wdata[i*DW +: DW] & {DW{win[i]}});
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_owner
      assign owner_mask[gi] = (owner_reg == IW'(gi));
      assign gnt[gi]        = owner_mask[gi] && (state_reg == ST_LAUNCH);
    end
  endgenerate

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= ST_IDLE;
      last_reg  <= IW'(NREQ - 1);
      owner_reg <= '0;
      tx_reg    <= '0;
      rdata_reg <= '0;
      wdog_reg  <= '0;
      done_reg  <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      owner_reg <= owner_next;
      tx_reg    <= tx_next;
      rdata_reg <= rdata_next;
      wdog_reg  <= wdog_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    owner_next = owner_reg;
    tx_next    = tx_reg;
    rdata_next = rdata_reg;
    wdog_next  = wdog_reg;
    done_next  = '0;
    err_next   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (active && win_valid && (BaudRateDivisor != 12'd0)) begin
          owner_next = win_idx;
          last_next  = win_idx;
          tx_next    = win_data;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wdog_next  = WDOG_TIP;
        state_next = ST_WAIT_TIP;
      end
      ST_WAIT_TIP: begin
        if (tip) begin
          wdog_next  = frame_load;
          state_next = ST_XFER;
        end else if (wdog_expire) begin
          err_next   = owner_mask;
          wdog_next  = GAP_LOAD;
          state_next = ST_GAP;
        end else begin
          wdog_next = wdog_reg - 17'd1;
        end
      end
      ST_XFER: begin
        // A completed frame wins over an abort or timeout in the same cycle.
        if (receive_data) begin
          rdata_next = rx_data;
          done_next  = owner_mask;
          wdog_next  = GAP_LOAD;
          state_next = ST_GAP;
        end else if (!active || wdog_expire) begin
          err_next   = owner_mask;
          wdog_next  = GAP_LOAD;
          state_next = ST_GAP;
        end else begin
          wdog_next = wdog_reg - 17'd1;
        end
      end
      ST_GAP: begin
        if (wdog_expire) begin
          wdog_next  = '0;
          state_next = ST_IDLE;
        end else begin
          wdog_next = wdog_reg - 17'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign done      = done_reg;
  assign err       = err_reg;
  assign rdata     = rdata_reg;
  assign tx_data   = tx_reg;
  assign owner     = owner_reg;
  assign send_data = (state_reg == ST_LAUNCH);
  assign busy      = (state_reg != ST_IDLE);

endmodule
